// File: rtl/zipmmu_tlbload_pkg.sv
// Shared definitions for the ZipCPU MMU TLB loader: FSM state encoding and
// the control-port address layout.
package zipmmu_tlbload_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WRV  = 2'b10,
    ST_WRP  = 2'b11
  } tlb_state_e;

  // Control address is {TBL_SEL, entry index, word select}
  localparam logic TBL_SEL = 1'b1;
  localparam logic W_VIRT  = 1'b0;
  localparam logic W_PHYS  = 1'b1;

endpackage

// File: rtl/zipmmu_tlbload.sv
// Hardware TLB loader: reads (virtual, physical) word pairs over pipelined
// Wishbone and writes each pair into the MMU control port.
module zipmmu_tlbload
  import zipmmu_tlbload_pkg::*;
#(
  parameter int AW    = 30,
  parameter int LGTBL = 6
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic [AW-1:0]    i_base,
  input  logic [LGTBL:0]   i_count,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [LGTBL:0]   o_loaded,
  output logic             o_mem_cyc,
  output logic             o_mem_stb,
  output logic [AW-1:0]    o_mem_addr,
  input  logic             i_mem_stall,
  input  logic             i_mem_ack,
  input  logic             i_mem_err,
  input  logic [31:0]      i_mem_data,
  output logic             o_mmu_stb,
  output logic             o_mmu_we,
  output logic [LGTBL+1:0] o_mmu_addr,
  output logic [31:0]      o_mmu_data,
  input  logic             i_mmu_ack,
  input  logic             i_mmu_stall
);

  localparam logic [LGTBL:0] MAX_CNT = {1'b1, {LGTBL{1'b0}}};
  localparam logic [LGTBL:0] ONE_K   = {{LGTBL{1'b0}}, 1'b1};
  localparam logic [AW-1:0]  ONE_A   = {{(AW-1){1'b0}}, 1'b1};

  tlb_state_e     state_r;
  logic [LGTBL:0] k_r;
  logic [LGTBL:0] count_r;
  logic [AW-1:0]  base_r;
  logic [1:0]     nreq_r;
  logic [1:0]     nack_r;
  logic [31:0]    vword_r;
  logic [31:0]    pword_r;

  logic [LGTBL:0] clamp_s;
  logic [LGTBL:0] k_next_s;
  logic [AW-1:0]  next_addr_s;
  logic           mem_accept_s;
  logic           mmu_accept_s;
  logic           mmu_ack_ok_s;

  // Count clamping, next-entry address and handshake qualifiers
  always_comb begin
    if (i_count > MAX_CNT) begin
      clamp_s = MAX_CNT;
    end else begin
      clamp_s = i_count;
    end
    k_next_s     = k_r + ONE_K;
    next_addr_s  = base_r + AW'({k_next_s, 1'b0});
    mem_accept_s = o_mem_stb && !i_mem_stall;
    mmu_accept_s = o_mmu_stb && !i_mmu_stall;
    // An ack only counts once the write has been (or is being) accepted
    mmu_ack_ok_s = i_mmu_ack && (!o_mmu_stb || !i_mmu_stall);
  end

  // Loader FSM with all bus outputs registered
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_r    <= ST_IDLE;
      k_r        <= '0;
      count_r    <= '0;
      base_r     <= '0;
      nreq_r     <= 2'd0;
      nack_r     <= 2'd0;
      vword_r    <= 32'd0;
      pword_r    <= 32'd0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      o_loaded   <= '0;
      o_mem_cyc  <= 1'b0;
      o_mem_stb  <= 1'b0;
      o_mem_addr <= '0;
      o_mmu_stb  <= 1'b0;
      o_mmu_we   <= 1'b0;
      o_mmu_addr <= '0;
      o_mmu_data <= 32'd0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // A start coinciding with the done/err pulse belongs to the old run
          if (i_start && !o_done && !o_err) begin
            if (clamp_s == '0) begin
              o_done <= 1'b1;
            end else begin
              base_r     <= i_base;
              count_r    <= clamp_s;
              k_r        <= '0;
              o_loaded   <= '0;
              nreq_r     <= 2'd0;
              nack_r     <= 2'd0;
              o_busy     <= 1'b1;
              o_mem_cyc  <= 1'b1;
              o_mem_stb  <= 1'b1;
              o_mem_addr <= i_base;
              state_r    <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (i_mem_err && o_mem_cyc) begin
            o_mem_cyc <= 1'b0;
            o_mem_stb <= 1'b0;
            o_err     <= 1'b1;
            o_busy    <= 1'b0;
            state_r   <= ST_IDLE;
          end else begin
            if (mem_accept_s) begin
              nreq_r <= nreq_r + 2'd1;
              if (nreq_r == 2'd0) begin
                o_mem_addr <= o_mem_addr + ONE_A;
              end else begin
                o_mem_stb <= 1'b0;
              end
            end
            if (i_mem_ack && (nack_r < 2'd2)) begin
              nack_r <= nack_r + 2'd1;
              if (nack_r == 2'd0) begin
                vword_r <= i_mem_data;
              end else begin
                pword_r    <= i_mem_data;
                o_mem_cyc  <= 1'b0;
                o_mmu_stb  <= 1'b1;
                o_mmu_we   <= 1'b1;
                o_mmu_addr <= {TBL_SEL, k_r[LGTBL-1:0], W_VIRT};
                o_mmu_data <= vword_r;
                state_r    <= ST_WRV;
              end
            end
          end
        end
        ST_WRV: begin
          if (mmu_accept_s) begin
            o_mmu_stb <= 1'b0;
          end
          if (mmu_ack_ok_s) begin
            o_mmu_stb  <= 1'b1;
            o_mmu_we   <= 1'b1;
            o_mmu_addr <= {TBL_SEL, k_r[LGTBL-1:0], W_PHYS};
            o_mmu_data <= pword_r;
            state_r    <= ST_WRP;
          end
        end
        ST_WRP: begin
          if (mmu_accept_s) begin
            o_mmu_stb <= 1'b0;
          end
          if (mmu_ack_ok_s) begin
            o_loaded <= k_next_s;
            k_r      <= k_next_s;
            if (k_next_s == count_r) begin
              o_done  <= 1'b1;
              o_busy  <= 1'b0;
              state_r <= ST_IDLE;
            end else begin
              nreq_r     <= 2'd0;
              nack_r     <= 2'd0;
              o_mem_cyc  <= 1'b1;
              o_mem_stb  <= 1'b1;
              o_mem_addr <= next_addr_s;
              state_r    <= ST_RD;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zipmmu_tlbload.sv
// Self-checking bench for zipmmu_tlbload: table-driven loads plus randomized
// stalls, checked against a list-level model of the expected bus traffic.
module tb_zipmmu_tlbload;

  localparam int AW     = 30;
  localparam int LGTBL  = 6;
  localparam int BUDGET = 5000;

  logic             i_clk = 1'b0;
  logic             i_reset_n;
  logic             i_start;
  logic [AW-1:0]    i_base;
  logic [LGTBL:0]   i_count;
  logic             o_busy, o_done, o_err;
  logic [LGTBL:0]   o_loaded;
  logic             o_mem_cyc, o_mem_stb;
  logic [AW-1:0]    o_mem_addr;
  logic             i_mem_stall, i_mem_ack, i_mem_err;
  logic [31:0]      i_mem_data;
  logic             o_mmu_stb, o_mmu_we;
  logic [LGTBL+1:0] o_mmu_addr;
  logic [31:0]      o_mmu_data;
  logic             i_mmu_ack, i_mmu_stall;

  always #5 i_clk = ~i_clk;

  zipmmu_tlbload #(.AW(AW), .LGTBL(LGTBL)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_base(i_base),
    .i_count(i_count), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_loaded(o_loaded), .o_mem_cyc(o_mem_cyc), .o_mem_stb(o_mem_stb),
    .o_mem_addr(o_mem_addr), .i_mem_stall(i_mem_stall), .i_mem_ack(i_mem_ack),
    .i_mem_err(i_mem_err), .i_mem_data(i_mem_data), .o_mmu_stb(o_mmu_stb),
    .o_mmu_we(o_mmu_we), .o_mmu_addr(o_mmu_addr), .o_mmu_data(o_mmu_data),
    .i_mmu_ack(i_mmu_ack), .i_mmu_stall(i_mmu_stall)
  );

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic [29:0] base;
    logic [6:0]  count;
    int          mem_pct;
    int          mmu_pct;
    int          err_k;
    logic [6:0]  exp_loaded;
    bit          exp_err;
  } vec_t;

  int tests = 0;
  int fails = 0;

  int          mem_pct = 0;
  int          mmu_pct = 0;
  bit          mmu_force = 1'b0;
  bit          err_armed = 1'b0;
  logic [29:0] err_addr = '0;
  bit          mmu_pend = 1'b0;
  int          we_bad = 0;
  logic [29:0] mem_pend[$];
  logic [29:0] rd_log[$];
  wr_t         wr_log[$];

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return ({2'b00, a} * 32'h9E37_79B1) + 32'h0BAD_F00D;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Memory slave: one response per cycle, one cycle after acceptance
  initial begin
    logic [29:0] a;
    i_mem_ack = 1'b0; i_mem_err = 1'b0; i_mem_stall = 1'b0; i_mem_data = 32'd0;
    forever begin
      @(negedge i_clk);
      i_mem_ack = 1'b0;
      i_mem_err = 1'b0;
      if (!i_reset_n || !o_mem_cyc) begin
        mem_pend.delete();
      end else if (mem_pend.size() > 0) begin
        a = mem_pend.pop_front();
        if (err_armed && a == err_addr) begin
          i_mem_err = 1'b1;
          err_armed = 1'b0;
        end else begin
          i_mem_ack  = 1'b1;
          i_mem_data = mem_word(a);
        end
      end
      i_mem_stall = (int'($urandom_range(0, 99)) < mem_pct);
      if (i_reset_n && o_mem_cyc && o_mem_stb && !i_mem_stall) begin
        mem_pend.push_back(o_mem_addr);
        rd_log.push_back(o_mem_addr);
      end
    end
  end

  // MMU control-port slave: ack same cycle as acceptance or later
  initial begin
    i_mmu_ack = 1'b0; i_mmu_stall = 1'b0;
    forever begin
      @(negedge i_clk);
      i_mmu_ack = 1'b0;
      if (!i_reset_n) begin
        mmu_pend = 1'b0;
      end else if (mmu_pend && (mmu_pct == 0 || $urandom_range(0, 1) == 1)) begin
        i_mmu_ack = 1'b1;
        mmu_pend  = 1'b0;
      end
      i_mmu_stall = mmu_force || (int'($urandom_range(0, 99)) < mmu_pct);
      if (i_reset_n && o_mmu_stb && !o_mmu_we) we_bad++;
      if (i_reset_n && o_mmu_stb && !i_mmu_stall) begin
        wr_log.push_back({o_mmu_addr, o_mmu_data});
        if (!i_mmu_ack && mmu_pct > 0 && $urandom_range(0, 1) == 1) i_mmu_ack = 1'b1;
        else mmu_pend = 1'b1;
      end
    end
  end

  task automatic run_load(input logic [29:0] base, input logic [6:0] cnt, input int mp,
                          input int wp, input int err_k, input logic [6:0] exp_loaded,
                          input bit exp_err, input bit sod);
    int n, lim, cyc_n, gaps, overlap, late;
    logic [29:0] exp_rd[$];
    wr_t exp_wr[$];
    n   = (cnt > 7'd64) ? 64 : int'(cnt);
    lim = (err_k >= 0) ? err_k : n;
    for (int k = 0; k < lim; k++) begin
      exp_wr.push_back({8'h80 + 8'(2 * k), mem_word(base + 30'(2 * k))});
      exp_wr.push_back({8'h81 + 8'(2 * k), mem_word(base + 30'(2 * k + 1))});
    end
    if (err_k < 0) begin
      for (int k = 0; k < n; k++) begin
        exp_rd.push_back(base + 30'(2 * k));
        exp_rd.push_back(base + 30'(2 * k + 1));
      end
    end
    mem_pct = mp; mmu_pct = wp; we_bad = 0;
    rd_log.delete(); wr_log.delete();
    err_armed = (err_k >= 0);
    err_addr  = base + 30'(2 * err_k);
    i_base = base; i_count = cnt; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    cyc_n = 0; gaps = 0; overlap = 0;
    while (!(o_done || o_err) && cyc_n < BUDGET) begin
      if (!o_busy) gaps++;
      if (o_mem_cyc && o_mmu_stb) overlap++;
      @(negedge i_clk);
      cyc_n++;
    end
    check("run_finished", {63'd0, o_done | o_err}, 64'd1);
    check("done_pulse", {63'd0, o_done}, {63'd0, !exp_err});
    check("err_pulse", {63'd0, o_err}, {63'd0, exp_err});
    check("busy_low_at_end", {63'd0, o_busy}, 64'd0);
    if (exp_err) check("cyc_dropped_on_err", {63'd0, o_mem_cyc}, 64'd0);
    if (n > 0) begin
      check("loaded", 64'(o_loaded), 64'(exp_loaded));
      check("busy_gaps", 64'(gaps), 64'd0);
    end else begin
      check("zero_count_latency", 64'(cyc_n), 64'd0);
    end
    check("cyc_mmu_overlap", 64'(overlap), 64'd0);
    if (sod) begin
      i_count = 7'd2; i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      late = 0;
      for (int i = 0; i < 6; i++) begin
        if (o_busy || o_mem_cyc || o_done) late++;
        @(negedge i_clk);
      end
      check("start_on_done_ignored", 64'(late), 64'd0);
    end else begin
      @(negedge i_clk);
      check("done_one_cycle", {63'd0, o_done | o_err}, 64'd0);
      repeat (3) @(negedge i_clk);
    end
    check("we_with_stb", 64'(we_bad), 64'd0);
    check("n_writes", 64'(wr_log.size()), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++) begin
      check($sformatf("wr%0d_addr", i), 64'(wr_log[i].a), 64'(exp_wr[i].a));
      check($sformatf("wr%0d_data", i), 64'(wr_log[i].d), 64'(exp_wr[i].d));
    end
    if (err_k < 0) begin
      check("n_reads", 64'(rd_log.size()), 64'(exp_rd.size()));
      for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
        check($sformatf("rd%0d_addr", i), 64'(rd_log[i]), 64'(exp_rd[i]));
    end
  endtask

  vec_t vecs[8];

  initial begin
    int cyc_n, rn, rk;
    i_reset_n = 1'b0; i_start = 1'b0; i_base = '0; i_count = '0;
    repeat (3) @(negedge i_clk);
    check("reset_state", {56'd0, o_busy, o_done, o_err, o_mem_cyc, o_mem_stb, o_mmu_stb, 2'b00}, 64'd0);
    check("reset_loaded", 64'(o_loaded), 64'd0);
    i_reset_n = 1'b1;
    @(negedge i_clk);

    vecs[0] = '{30'h0000_4000, 7'd3,   0,  0, -1, 7'd3,  1'b0};
    vecs[1] = '{30'h0000_4000, 7'd5,   0,  0,  2, 7'd2,  1'b1};
    vecs[2] = '{30'h0000_0777, 7'd4,  25, 25, -1, 7'd4,  1'b0};
    vecs[3] = '{30'h0000_0000, 7'd0,   0,  0, -1, 7'd0,  1'b0};
    vecs[4] = '{30'h0000_0100, 7'd127, 0,  0, -1, 7'd64, 1'b0};
    vecs[5] = '{30'h3FFF_FFFE, 7'd2,   0,  0, -1, 7'd2,  1'b0};
    vecs[6] = '{30'h0000_2000, 7'd64, 50, 50, -1, 7'd64, 1'b0};
    vecs[7] = '{30'h0000_0123, 7'd1,  50,  0,  0, 7'd0,  1'b1};
    for (int v = 0; v < 8; v++)
      run_load(vecs[v].base, vecs[v].count, vecs[v].mem_pct, vecs[v].mmu_pct,
               vecs[v].err_k, vecs[v].exp_loaded, vecs[v].exp_err, 1'b0);

    // Start presented in the same cycle as the done pulse
    run_load(30'h0000_0050, 7'd1, 0, 0, -1, 7'd1, 1'b0, 1'b1);

    // Reset while the virtual-word write of entry 1 is stalled
    mem_pct = 0; mmu_pct = 0; mmu_force = 1'b0;
    i_base = 30'h0000_0010; i_count = 7'd2; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    cyc_n = 0;
    while (o_loaded != 7'd1 && cyc_n < 200) begin @(negedge i_clk); cyc_n++; end
    mmu_force = 1'b1;
    while (!o_mmu_stb && cyc_n < 400) begin @(negedge i_clk); cyc_n++; end
    check("reached_stalled_wrv", {62'd0, o_mmu_stb, o_loaded == 7'd1}, 64'd3);
    i_reset_n = 1'b0;
    @(negedge i_clk);
    check("reset_mid_run", {56'd0, o_busy, o_done, o_err, o_mem_cyc, o_mem_stb, o_mmu_stb, 2'b00}, 64'd0);
    check("reset_mid_loaded", 64'(o_loaded), 64'd0);
    mmu_force = 1'b0;
    i_reset_n = 1'b1;
    @(negedge i_clk);

    // Randomized runs with 50% stalls on both ports, one ending in a bus error
    for (int r = 0; r < 5; r++) begin
      rn = int'($urandom_range(1, 80));
      if (r == 4) begin
        rk = int'($urandom_range(0, 63));
        if (rk >= rn && rn <= 64) rk = rn - 1;
        run_load(30'($urandom), 7'(rn), 50, 50, rk, 7'(rk), 1'b1, 1'b0);
      end else begin
        run_load(30'($urandom), 7'(rn), 50, 50, -1, 7'((rn > 64) ? 64 : rn), 1'b0, 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
